sound_event_arbiter: RTL and testbench

- Sits between the game logic (shot, explosion and invader-step detectors) and the existing sound sequencing FSM.
- Latches single-cycle sound requests and arbitrates them by fixed priority.
- Issues exactly one start pulse at a time to the sound FSM, waits for that sound to finish, then enforces a hold-off gap before the next grant.
- Prevents simultaneous game events from colliding on the single shared sound datapath.

---
 rtl/sound_event_arbiter_pkg.sv | 43 ++++
 rtl/sound_prio_enc.sv | 28 ++
 rtl/sound_event_arbiter.sv | 154 +++++++++++++++
 tb/tb_sound_event_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_event_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sound_event_arbiter_pkg
// Description : Shared encodings for the sound event arbiter and future sound
//               blocks. Includes state codes, pending-bit indices and
//               sound-event codes.
// Revision    : 1.0 - initial release
// ============================================================================
package sound_event_arbiter_pkg;

    // Arbiter state encoding.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_START = START,
        ST_RUN   = RUN,
        ST_GAP   = GAP
    } arb_state_e;

    // Bit positions inside the 3-bit pending/grant vectors.
    localparam int PEND_DES = 2;
    localparam int PEND_DIS = 1;
    localparam int PEND_MOV = 0;

    // Sound-event codes shared with other sound blocks.
    typedef enum logic [1:0] {
        SND_NONE     = 2'd0,
        SND_MOVIO    = 2'd1,
        SND_DISPARO  = 2'd2,
        SND_DESTRUYO = 2'd3
    } sound_evt_e;

    // Population count of a 3-bit vector.
    function automatic logic [1:0] count_ones3(input logic [2:0] v);
        return 2'({1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]});
    endfunction

endpackage
`default_nettype wire

// File: rtl/sound_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : sound_prio_enc
// Description : Combinational fixed-priority encoder for sound requests.
//               destruyo > disparo > movio. The output is one-hot, or zero.
// Revision    : 1.0 - initial release
// ============================================================================
module sound_prio_enc
    import sound_event_arbiter_pkg::*;
(
    input  logic [2:0] req,
    output logic [2:0] gnt
);

    // Highest-priority request wins; the order is fixed and does not rotate.
    always_comb begin
        gnt = 3'b000;
        if (req[PEND_DES]) begin
            gnt[PEND_DES] = 1'b1;
        end else if (req[PEND_DIS]) begin
            gnt[PEND_DIS] = 1'b1;
        end else if (req[PEND_MOV]) begin
            gnt[PEND_MOV] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sound_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sound_event_arbiter
// Description : Latches single-cycle game sound requests and issues one start
//               pulse at a time to the sound FSM. After each pulse it waits for
//               the sound to finish, then holds off for GAP_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module sound_event_arbiter
    import sound_event_arbiter_pkg::*;
#(
    parameter int GAP_CYCLES = 16,
    parameter int START_TO   = 8,
    parameter int CNT_W      = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_disparo,
    input  logic             req_destruyo,
    input  logic             req_movio,
    input  logic             mute,
    input  logic             sonido_idle,
    output logic             disparo,
    output logic             destruyo,
    output logic             movio,
    output logic             busy,
    output logic [2:0]       pend,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             err_timeout
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TO_W  = $clog2(START_TO);

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(START_TO - 1);

    arb_state_e       state_q, state_d;
    logic [2:0]       pend_q, pend_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             err_q, err_d;
    logic [2:0]       pulse_q, pulse_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

    logic [2:0]       req_vec;
    logic [2:0]       pend_eff;
    logic [2:0]       gnt_cand;
    logic [2:0]       grant;
    logic [2:0]       drops;
    logic [CNT_W:0]   drop_sum;

    assign req_vec  = {req_destruyo, req_disparo, req_movio};
    // A request arriving this cycle may be granted immediately without first
    // sitting in the pending register.
    assign pend_eff = pend_q | req_vec;

    sound_prio_enc u_prio (
        .req (pend_eff),
        .gnt (gnt_cand)
    );

    // Next-state logic and grant decision for the arbiter FSM.
    always_comb begin
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;
        err_d     = err_q;
        grant     = 3'b000;
        case (state_q)
            ST_IDLE: begin
                if (!mute && sonido_idle && (pend_eff != 3'b000)) begin
                    grant    = gnt_cand;
                    state_d  = ST_START;
                    to_cnt_d = '0;
                end
            end
            ST_START: begin
                if (!sonido_idle) begin
                    state_d = ST_RUN;
                end else if (to_cnt_q == TO_LAST) begin
                    // The sound FSM never responded, so the granted request is dropped.
                    err_d     = 1'b1;
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (sonido_idle) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        pulse_d = grant;
    end

    // Pending-bit update and saturating drop counter.
    always_comb begin
        // A grant consumes its bit. A same-type request in the same cycle
        // re-arms the bit only if that request was not the one just consumed.
        pend_d   = (pend_q & ~grant) | (req_vec & ~(grant & ~pend_q));
        drops    = req_vec & pend_q & ~grant;
        drop_sum = {1'b0, drop_cnt_q} + (CNT_W+1)'(count_ones3(drops));
        if (drop_sum[CNT_W]) begin
            drop_cnt_d = '1;
        end else begin
            drop_cnt_d = drop_sum[CNT_W-1:0];
        end
    end

    // State and datapath registers. Reset is asynchronous and active-low.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            pend_q     <= 3'b000;
            drop_cnt_q <= '0;
            err_q      <= 1'b0;
            pulse_q    <= 3'b000;
            gap_cnt_q  <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            drop_cnt_q <= drop_cnt_d;
            err_q      <= err_d;
            pulse_q    <= pulse_d;
            gap_cnt_q  <= gap_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign destruyo    = pulse_q[PEND_DES];
    assign disparo     = pulse_q[PEND_DIS];
    assign movio       = pulse_q[PEND_MOV];
    assign busy        = (state_q != ST_IDLE);
    assign pend        = pend_q;
    assign drop_cnt    = drop_cnt_q;
    assign err_timeout = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sound_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sound_event_arbiter
// Description : Directed testbench for sound_event_arbiter. Expected start
//               pulses are queued with their cycle numbers, and a negedge
//               monitor checks them as they appear. Status outputs are checked
//               inline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sound_event_arbiter;

    logic       CLK;
    logic       RST;
    logic       req_disparo, req_destruyo, req_movio;
    logic       mute, sonido_idle;
    logic       disparo, destruyo, movio;
    logic       busy;
    logic [2:0] pend;
    logic [7:0] drop_cnt;
    logic       err_timeout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [2:0] exp_v[$];
    int         exp_c[$];
    logic [2:0] mon_v;
    logic [2:0] mon_e;
    int         mon_ec;

    sound_event_arbiter #(
        .GAP_CYCLES (16),
        .START_TO   (8),
        .CNT_W      (8)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .req_disparo  (req_disparo),
        .req_destruyo (req_destruyo),
        .req_movio    (req_movio),
        .mute         (mute),
        .sonido_idle  (sonido_idle),
        .disparo      (disparo),
        .destruyo     (destruyo),
        .movio        (movio),
        .busy         (busy),
        .pend         (pend),
        .drop_cnt     (drop_cnt),
        .err_timeout  (err_timeout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [2:0] v, input int c);
        exp_v.push_back(v);
        exp_c.push_back(c);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Called in the cycle the start pulse is visible. Plays a sound of len
    // cycles, then checks the gap. Returns in the cycle after the gap
    // (i.e. the next pulse cycle, if anything is pending).
    task automatic serve(input int len, input logic [2:0] nxt);
        int r;
        tick();
        sonido_idle = 1'b0;
        repeat (len) tick();
        sonido_idle = 1'b1;
        r = cyc;
        if (nxt != 3'b000) push_exp(nxt, r + 18);
        repeat (16) tick();
        chk("busy_gap_end", busy, 1);
        tick();
        chk("busy_after_gap", busy, 0);
        tick();
    endtask

    // Scoreboard monitor: each start pulse must match the head of the queue.
    always @(negedge CLK) begin
        if (RST) begin
            mon_v = {destruyo, disparo, movio};
            if (mon_v != 3'b000) begin
                if (exp_v.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: got %b expected none (cycle %0d)", mon_v, cyc);
                end else begin
                    mon_e  = exp_v.pop_front();
                    mon_ec = exp_c.pop_front();
                    total++;
                    if (mon_v !== mon_e || cyc != mon_ec) begin
                        bad++;
                        $display("FAIL pulse: got %b at cycle %0d expected %b at cycle %0d",
                                 mon_v, cyc, mon_e, mon_ec);
                    end
                end
            end
        end
    end

    initial begin
        RST          = 1'b0;
        req_disparo  = 1'b0;
        req_destruyo = 1'b0;
        req_movio    = 1'b0;
        mute         = 1'b0;
        sonido_idle  = 1'b1;

        // Reset state
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_pend", pend, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_pulses", {destruyo, disparo, movio}, 0);
        repeat (3) tick();
        RST = 1'b1;
        repeat (3) tick();
        chk("idle_busy", busy, 0);

        // Single shot
        req_disparo = 1'b1;
        push_exp(3'b010, cyc + 1);
        tick();
        req_disparo = 1'b0;
        chk("shot_busy", busy, 1);
        chk("shot_pend", pend, 0);
        serve(20, 3'b000);
        chk("shot_pend_end", pend, 0);

        // Three simultaneous requests
        req_destruyo = 1'b1;
        req_disparo  = 1'b1;
        req_movio    = 1'b1;
        push_exp(3'b100, cyc + 1);
        tick();
        req_destruyo = 1'b0;
        req_disparo  = 1'b0;
        req_movio    = 1'b0;
        chk("sim_pend", pend, 3'b011);
        chk("sim_drop", drop_cnt, 0);
        serve(10, 3'b010);
        chk("sim_pend2", pend, 3'b001);
        serve(10, 3'b001);
        chk("sim_pend3", pend, 3'b000);
        serve(10, 3'b000);
        chk("sim_drop_end", drop_cnt, 0);

        // Coalescing movio requests during RUN
        req_disparo = 1'b1;
        push_exp(3'b010, cyc + 1);
        tick();
        req_disparo = 1'b0;
        tick();
        sonido_idle = 1'b0;
        tick();
        req_movio = 1'b1;
        repeat (3) tick();
        req_movio = 1'b0;
        chk("coal_pend", pend, 3'b001);
        chk("coal_drop", drop_cnt, 2);
        repeat (5) tick();
        sonido_idle = 1'b1;
        push_exp(3'b001, cyc + 18);
        repeat (18) tick();
        chk("coal_pend_clr", pend, 0);
        serve(4, 3'b000);
        chk("coal_drop_end", drop_cnt, 2);

        // Mute holds a request pending
        mute = 1'b1;
        req_destruyo = 1'b1;
        tick();
        req_destruyo = 1'b0;
        chk("mute_pend", pend, 3'b100);
        chk("mute_busy", busy, 0);
        repeat (3) tick();
        chk("mute_pend_hold", pend, 3'b100);
        mute = 1'b0;
        push_exp(3'b100, cyc + 1);
        tick();
        chk("unmute_pend", pend, 0);
        serve(3, 3'b000);

        // Start timeout: sonido_idle never drops
        req_destruyo = 1'b1;
        push_exp(3'b100, cyc + 1);
        tick();
        req_destruyo = 1'b0;
        repeat (7) tick();
        chk("to_err_before", err_timeout, 0);
        chk("to_busy", busy, 1);
        tick();
        chk("to_err_set", err_timeout, 1);
        repeat (16) tick();
        chk("to_busy_idle", busy, 0);
        chk("to_err_sticky", err_timeout, 1);
        chk("to_pend", pend, 0);

        // Drop counter saturation while muted
        mute = 1'b1;
        req_movio = 1'b1;
        repeat (300) tick();
        req_movio = 1'b0;
        chk("sat_drop", drop_cnt, 8'hFF);
        chk("sat_pend", pend, 3'b001);
        mute = 1'b0;
        push_exp(3'b001, cyc + 1);
        tick();
        tick();
        sonido_idle = 1'b0;
        tick();
        req_disparo = 1'b1;
        tick();
        req_disparo = 1'b0;
        chk("run_busy", busy, 1);
        chk("run_pend", pend, 3'b010);
        chk("run_err", err_timeout, 1);
        chk("run_drop", drop_cnt, 8'hFF);

        // Asynchronous reset mid-RUN, between clock edges
        #2;
        RST = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_pend", pend, 0);
        chk("arst_drop", drop_cnt, 0);
        chk("arst_err", err_timeout, 0);
        chk("arst_pulses", {destruyo, disparo, movio}, 0);
        sonido_idle = 1'b1;
        tick();
        tick();
        #2;
        RST = 1'b1;
        repeat (4) tick();
        chk("post_busy", busy, 0);
        chk("queue_empty", exp_v.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
